// File: rtl/capi_pkg.sv
// CAPI command-buffer line and downstream buffer status shared by the AFU command path.
package capi_pkg;

  typedef struct packed {
    logic        valid;
    logic [12:0] command;
    logic [7:0]  tag;
    logic [11:0] size;
    logic [63:0] address;
  } command_buffer_line_t;

  typedef struct packed {
    logic alfull;
  } buffer_status_t;

endpackage

// File: rtl/cu_command_arbiter_pkg.sv
// Shared arbiter types and the round-robin one-hot selector.
package cu_command_arbiter_pkg;

  localparam int CU_ARB_MAX_REQUESTERS = 8;
  localparam int CU_ARB_PTR_W          = $clog2(CU_ARB_MAX_REQUESTERS);

  typedef logic [0:CU_ARB_MAX_REQUESTERS-1] arbiter_grant_t;

  // Unused request bits are zero, so scanning modulo the maximum width gives
  // the same winner as scanning modulo the real requester count.
  function automatic arbiter_grant_t rr_select(input arbiter_grant_t request,
                                               input logic [CU_ARB_PTR_W-1:0] ptr);
    arbiter_grant_t grant;
    logic [CU_ARB_PTR_W-1:0] idx;
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < CU_ARB_MAX_REQUESTERS; i++) begin
      idx = ptr + CU_ARB_PTR_W'(i);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/cu_command_fifo.sv
// Show-ahead synchronous FIFO of command lines; a push into a full FIFO is accepted only with a same-cycle pop.
module cu_command_fifo
  import capi_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int MARGIN = 2
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 push,
  input  logic                 pop,
  input  command_buffer_line_t data_in,
  output command_buffer_line_t data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 alfull
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  command_buffer_line_t mem [0:DEPTH-1];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop_ok;
  logic          push_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign alfull   = (count >= CW'(DEPTH - MARGIN));
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/cu_command_arbiter.sv
// Round-robin arbiter sharing one CAPI command buffer among per-requester FIFOs.
// Optional per-requester grant counters are built when CU_ARBITER_STATS_EN is defined.
module cu_command_arbiter
  import capi_pkg::*;
  import cu_command_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS     = 2,
  parameter int FIFO_DEPTH         = 16,
  parameter int FIFO_ALFULL_MARGIN = 2
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      enabled_in,
  input  command_buffer_line_t      command_in [0:NUM_REQUESTERS-1],
  output logic                      ready_out [0:NUM_REQUESTERS-1],
  input  buffer_status_t            command_buffer_status,
  output command_buffer_line_t      command_out,
  output logic [NUM_REQUESTERS-1:0] grant_out,
  output logic [NUM_REQUESTERS-1:0] overflow_error
`ifdef CU_ARBITER_STATS_EN
  ,
  output logic [31:0]               grant_count [0:NUM_REQUESTERS-1]
`endif
);

  logic                      enabled_q;
  logic [CU_ARB_PTR_W-1:0]   rr_ptr;
  logic [CU_ARB_PTR_W-1:0]   rr_ptr_next;
  command_buffer_line_t      fifo_data [0:NUM_REQUESTERS-1];
  logic [NUM_REQUESTERS-1:0] fifo_empty;
  logic [NUM_REQUESTERS-1:0] fifo_full;
  logic [NUM_REQUESTERS-1:0] fifo_alfull;
  logic [NUM_REQUESTERS-1:0] push;
  logic [NUM_REQUESTERS-1:0] pop;
  logic [NUM_REQUESTERS-1:0] grant_next;
  arbiter_grant_t            request;
  arbiter_grant_t            grant_vec;
  command_buffer_line_t      selected;
  logic                      eligible;

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_fifo
    cu_command_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .MARGIN (FIFO_ALFULL_MARGIN)
    ) u_fifo (
      .clock    (clock),
      .rstn     (rstn),
      .push     (push[g]),
      .pop      (pop[g]),
      .data_in  (command_in[g]),
      .data_out (fifo_data[g]),
      .empty    (fifo_empty[g]),
      .full     (fifo_full[g]),
      .alfull   (fifo_alfull[g])
    );
  end

  always_comb begin
    push    = '0;
    request = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      push[i]    = enabled_q & command_in[i].valid;
      request[i] = ~fifo_empty[i];
    end
  end

  assign eligible  = enabled_q & ~command_buffer_status.alfull & (|request);
  assign grant_vec = rr_select(request, rr_ptr);

  always_comb begin
    pop         = '0;
    grant_next  = '0;
    selected    = '0;
    rr_ptr_next = rr_ptr;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (eligible && grant_vec[i]) begin
        pop[i]        = 1'b1;
        grant_next[i] = 1'b1;
        selected      = fifo_data[i];
        rr_ptr_next   = (i == NUM_REQUESTERS - 1) ? '0 : CU_ARB_PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled_q      <= 1'b0;
      rr_ptr         <= '0;
      command_out    <= '0;
      grant_out      <= '0;
      overflow_error <= '0;
    end else begin
      enabled_q      <= enabled_in;
      rr_ptr         <= rr_ptr_next;
      overflow_error <= overflow_error | (push & fifo_full & ~pop);
      if (eligible) begin
        command_out       <= selected;
        command_out.valid <= 1'b1;
        grant_out         <= grant_next;
      end else begin
        command_out <= '0;
        grant_out   <= '0;
      end
    end
  end

  // alfull leaves two free slots so the registered ready still lands before full
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQUESTERS; i++) ready_out[i] <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) ready_out[i] <= enabled_q & ~fifo_alfull[i];
    end
  end

`ifdef CU_ARBITER_STATS_EN
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQUESTERS; i++) grant_count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        if (grant_next[i] && (grant_count[i] != 32'hFFFF_FFFF))
          grant_count[i] <= grant_count[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cu_command_arbiter.sv
// Directed bench for cu_command_arbiter (2 requesters, 4-deep FIFOs, margin 2).
module tb_cu_command_arbiter;
  import capi_pkg::*;

  logic                 clock;
  logic                 rstn;
  logic                 enabled_in;
  command_buffer_line_t command_in [0:1];
  logic                 ready_out [0:1];
  buffer_status_t       command_buffer_status;
  command_buffer_line_t command_out;
  logic [1:0]           grant_out;
  logic [1:0]           overflow_error;
`ifdef CU_ARBITER_STATS_EN
  logic [31:0]          grant_count [0:1];
`endif

  int nvec = 0;
  int nerr = 0;

  cu_command_arbiter #(
    .NUM_REQUESTERS     (2),
    .FIFO_DEPTH         (4),
    .FIFO_ALFULL_MARGIN (2)
  ) dut (
    .clock                 (clock),
    .rstn                  (rstn),
    .enabled_in            (enabled_in),
    .command_in            (command_in),
    .ready_out             (ready_out),
    .command_buffer_status (command_buffer_status),
    .command_out           (command_out),
    .grant_out             (grant_out),
    .overflow_error        (overflow_error)
`ifdef CU_ARBITER_STATS_EN
    ,
    .grant_count           (grant_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic command_buffer_line_t mk(input logic [7:0] tag);
    command_buffer_line_t l;
    l         = '0;
    l.valid   = 1'b1;
    l.tag     = tag;
    l.command = {5'b0, ~tag};
    l.size    = 12'd128;
    l.address = 64'h0000_1000_0000_0000 | {48'h0, tag, 8'h40};
    return l;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // tag 0 means an idle output: command_out and grant_out both zero
  task automatic check_out(input string name, input logic [7:0] tag, input logic [1:0] g);
    command_buffer_line_t exp;
    exp = (tag == 8'h00) ? '0 : mk(tag);
    nvec++;
    assert (command_out === exp && grant_out === g) else begin
      nerr++;
      $error("FAIL %s: observed tag %0h valid %0b grant %b expected tag %0h grant %b",
             name, command_out.tag, command_out.valid, grant_out, tag, g);
    end
  endtask

  logic [7:0] fair_tag [0:7] = '{8'h00, 8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h00};
  logic [1:0] fair_g   [0:7] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
  logic [7:0] bp_tag   [0:5] = '{8'h30, 8'h40, 8'h31, 8'h41, 8'h32, 8'h00};
  logic [1:0] bp_g     [0:5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};

  initial begin
    rstn                  = 1'b0;
    enabled_in            = 1'b0;
    command_in[0]         = '0;
    command_in[1]         = '0;
    command_buffer_status = '0;
    tick();
    tick();
    check_out("reset_out", 8'h00, 2'b00);
    check("reset_ready0", 32'(ready_out[0]), 32'd0);
    check("reset_ready1", 32'(ready_out[1]), 32'd0);
    check("reset_overflow", 32'(overflow_error), 32'd0);

    rstn       = 1'b1;
    enabled_in = 1'b1;
    tick();
    check("ready_lag1", 32'(ready_out[0]), 32'd0);
    tick();
    check("ready_on0", 32'(ready_out[0]), 32'd1);
    check("ready_on1", 32'(ready_out[1]), 32'd1);

    // single source, four back-to-back pushes
    for (int k = 0; k < 6; k++) begin
      command_in[0] = (k < 4) ? mk(8'(k + 1)) : '0;
      tick();
      check_out("single_src", (k >= 1 && k <= 4) ? 8'(k) : 8'h00,
                (k >= 1 && k <= 4) ? 2'b01 : 2'b00);
    end

    // one entry on requester 1 moves the pointer back to 0
    command_in[1] = mk(8'h09);
    tick();
    command_in[1] = '0;
    check_out("r1_first_cycle", 8'h00, 2'b00);
    tick();
    check_out("r1_single", 8'h09, 2'b10);
    tick();
    check_out("r1_idle", 8'h00, 2'b00);

    // fairness
    for (int j = 0; j < 8; j++) begin
      command_in[0] = (j < 3) ? mk(8'(8'h10 + j)) : '0;
      command_in[1] = (j < 3) ? mk(8'(8'h20 + j)) : '0;
      tick();
      check_out("fairness", fair_tag[j], fair_g[j]);
    end

    // backpressure
    command_buffer_status.alfull = 1'b1;
    for (int j = 0; j < 10; j++) begin
      command_in[0] = (j < 3) ? mk(8'(8'h30 + j)) : '0;
      command_in[1] = (j < 2) ? mk(8'(8'h40 + j)) : '0;
      tick();
      check_out("bp_hold", 8'h00, 2'b00);
    end
    check("bp_ready0", 32'(ready_out[0]), 32'd0);
    check("bp_ready1", 32'(ready_out[1]), 32'd0);
    command_buffer_status.alfull = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      check_out("bp_drain", bp_tag[j], bp_g[j]);
    end

    // fill requester 1 past full
    command_buffer_status.alfull = 1'b1;
    for (int j = 0; j < 5; j++) begin
      command_in[1] = mk(8'(8'h50 + j));
      tick();
      if (j == 1) check("full_ready_hi", 32'(ready_out[1]), 32'd1);
      if (j == 2) check("full_ready_lo", 32'(ready_out[1]), 32'd0);
      if (j == 3) check("full_no_ovf", 32'(overflow_error), 32'd0);
      if (j == 4) check("full_ovf", 32'(overflow_error), 32'b10);
    end
    command_in[1]                = '0;
    command_buffer_status.alfull = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check_out("full_drain", (j < 4) ? 8'(8'h50 + j) : 8'h00, (j < 4) ? 2'b10 : 2'b00);
    end
    check("ovf_sticky", 32'(overflow_error), 32'b10);

    // pushes while disabled are dropped
    enabled_in = 1'b0;
    tick();
    tick();
    check("dis_ready0", 32'(ready_out[0]), 32'd0);
    command_in[0] = mk(8'h60);
    tick();
    command_in[0] = '0;
    enabled_in    = 1'b1;
    tick();
    tick();
    check_out("dis_no_store_a", 8'h00, 2'b00);
    tick();
    check_out("dis_no_store_b", 8'h00, 2'b00);

`ifdef CU_ARBITER_STATS_EN
    check("stats_r0", grant_count[0], 32'd10);
    check("stats_r1", grant_count[1], 32'd10);
`endif

    // reset mid-burst
    command_buffer_status.alfull = 1'b1;
    for (int j = 0; j < 3; j++) begin
      command_in[0] = mk(8'(8'h70 + j));
      tick();
    end
    command_in[0]                = '0;
    command_buffer_status.alfull = 1'b0;
    tick();
    check_out("rst_pre", 8'h70, 2'b01);
    rstn = 1'b0;
    #1;
    check_out("rst_async", 8'h00, 2'b00);
    check("rst_ovf_clr", 32'(overflow_error), 32'd0);
    @(negedge clock);
    rstn = 1'b1;
    tick();
    check("rst_ready_lag", 32'(ready_out[0]), 32'd0);
    check_out("rst_no_stale_a", 8'h00, 2'b00);
    tick();
    check("rst_ready_back", 32'(ready_out[0]), 32'd1);
    check_out("rst_no_stale_b", 8'h00, 2'b00);
    tick();
    check_out("rst_no_stale_c", 8'h00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cu_command_arbiter.md
Name: cu_command_arbiter

Overview:
- Round-robin arbiter that shares the single CAPI read (or write) command buffer among NUM_REQUESTERS compute-unit command sources, e.g. the read and write engines of several CUs.
- Each requester pushes CommandBufferLine entries into a private FIFO.
- The arbiter pops at most one entry per cycle into a registered command_out, throttled by the downstream BufferStatus.
- Sits between the CU engine controls and the AFU command buffer.

Parameters:
- NUM_REQUESTERS, 2, number of command sources (2..8).
- FIFO_DEPTH, 16, entries per requester FIFO (power of two, at least 4).
- FIFO_ALFULL_MARGIN, 2, free entries remaining when ready_out drops.

Ports:
- clock  in  1  system clock
- rstn  in  1  reset
- enabled_in  in  1  block enable; registered internally, one-cycle delay
- command_in[0:NUM_REQUESTERS-1]  in  CommandBufferLine each  push entry; pushes when .valid=1
- ready_out[0:NUM_REQUESTERS-1]  out  1 each  requester may push (FIFO not almost-full)
- command_buffer_status  in  BufferStatus  downstream status; .alfull blocks pops
- command_out  out  CommandBufferLine  granted command, registered
- grant_out  out  NUM_REQUESTERS  one-hot id of the source of command_out, valid with command_out.valid
- overflow_error  out  NUM_REQUESTERS  sticky per requester: push attempted while FIFO full

Interface decision (already decided): one clock, clock; reset rstn is asynchronous and active-low.

Behaviour:
- Reset: command_out=0, grant_out=0, ready_out=0, overflow_error=0, FIFOs empty, RR pointer=0, enabled register=0.
- ready_out[i] is registered and equals enabled & (count_i <= FIFO_DEPTH-FIFO_ALFULL_MARGIN-1).
  - ready_out drops 2 cycles before full, which covers its own one-cycle lag.
- Push:
  - Occurs when enabled and command_in[i].valid.
  - If FIFO i is full, the entry is dropped and overflow_error[i] is set; it stays set until reset.
  - Pushes while disabled are ignored.
- Pop eligibility: enabled & ~command_buffer_status.alfull & at least one non-empty FIFO.
- Arbitration: scan from RR pointer p upward, modulo NUM_REQUESTERS; the first non-empty FIFO k wins. After a grant, p <= (k+1) mod NUM_REQUESTERS. p is unchanged when nothing is granted.
- Latency: an entry pushed into an empty FIFO at cycle t can appear on command_out at t+2 (FIFO write at t, arbitration and pop at t+1, output register at t+2).
- command_out:
  - Holds the popped entry for exactly one cycle with .valid=1; otherwise command_out=0 and grant_out=0.
  - No bubble between back-to-back grants: sustained throughput is 1 command per cycle.
- Simultaneous push and pop on the same FIFO: allowed, count unchanged. Push into full FIFO with simultaneous pop: accepted, no overflow.
- Count width: $clog2(FIFO_DEPTH)+1, so full and empty are distinguishable. Read and write pointers wrap modulo FIFO_DEPTH.
- alfull asserted mid-burst: the pop stops the same cycle alfull is seen. The entry already in the output register still issues.
- enabled_in deasserted: pops and pushes stop; FIFO contents and p are retained; output returns to 0 the next cycle.
- Async reset mid-operation: all state, including pending entries, is cleared immediately.

Optional Feature:
- Macro: CU_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_count[0:NUM_REQUESTERS-1], 32 bits each.
  - Each counter increments on every grant to that requester and saturates at 32'hFFFF_FFFF.
  - Reset to 0.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- CU_PKG gets:
  - CU_ARB_MAX_REQUESTERS = 8;
  - typedef ArbiterGrant (logic [0:CU_ARB_MAX_REQUESTERS-1]);
  - a function rr_select(request vector, pointer) that returns a one-hot grant.
- CommandBufferLine and BufferStatus come from CAPI_PKG.
- Sub-module cu_command_fifo: synchronous FIFO with push, pop, data, empty, full, alfull and count, parameterized by depth and margin. One instance per requester via generate.

Test Plan:
- Single source: 4 commands on requester 0 in consecutive cycles, alfull=0 -> command_out.valid on 4 consecutive cycles starting 2 cycles after the first push; grant_out=01 each time; order preserved.
- Fairness: both requesters push 3 commands each continuously, p=0 -> grant sequence 0,1,0,1,0,1.
- Backpressure: alfull=1 for 10 cycles while 5 entries are queued -> no command_out.valid; after alfull drops, 5 commands issue back-to-back.
- Full FIFO (FIFO_DEPTH=4, margin 2): ready_out[1] drops after 2 queued. Force 5 pushes with alfull=1 -> first 4 stored, 5th dropped, overflow_error[1]=1 and stays set.
- Reset mid-burst: rstn low with 3 entries queued -> command_out=0 immediately; after release, no stale commands issue and ready_out returns 1 two cycles after enabled_in.
- With CU_ARBITER_STATS_EN: 7 grants to requester 0 and 3 to requester 1 -> grant_count = {7,3}.
